// File: rtl/cpu_controller_pkg.sv
// Shared opcode and sequencer-phase encodings for the controller, ALU and instruction register.
package cpu_defs;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  localparam int PHASE_W = 3;

  // Instructions that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction-decode inputs and control strobes between the controller and the datapath.
interface cpu_controller_if;
  import cpu_defs::*;

  logic [PHASE_W-1:0] opcode;
  logic               zero;
  logic [PHASE_W-1:0] phase;
  logic               sel;
  logic               rd;
  logic               ld_ir;
  logic               halt;
  logic               inc_pc;
  logic               ld_pc;
  logic               ld_ac;
  logic               wr;
  logic               data_e;

  modport master (
    input  opcode, zero,
    output phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e
  );

  modport slave (
    output opcode, zero,
    input  phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e
  );
endinterface

// File: rtl/cpu_controller_phase_counter.sv
// Eight-phase instruction sequencer: wraps 7->0, freezes while hold is high.
module phase_counter
  import cpu_defs::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= PH_INST_ADDR;
    end else if (!hold) begin
      phase_reg <= phase_reg + 3'd1;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/cpu_controller.sv
// Control-strobe decode and sticky halt flag for the eight-phase CPU sequencer.
module cpu_controller
  import cpu_defs::*;
(
  input  logic               clk,
  input  logic               rst,
  cpu_controller_if.master   bus
);

  logic               halt_reg;
  logic               halt_now;
  logic [PHASE_W-1:0] phase_raw;
  phase_t             ph;
  opcode_t            op;
  logic               aluop;

  logic sel_c, rd_c, ld_ir_c, halt_c, inc_pc_c, ld_pc_c, ld_ac_c, wr_c, data_e_c;

  assign ph    = phase_t'(phase_raw);
  assign op    = opcode_t'(bus.opcode);
  assign aluop = is_aluop(op);

  // The phase must not advance on the edge that latches a new HLT, so hold
  // covers the decode cycle as well as the sticky flag.
  assign halt_now = !rst && (halt_reg || (ph == PH_OP_ADDR && op == OP_HLT));

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .hold  (halt_now),
    .phase (phase_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_reg <= 1'b0;
    end else if (halt_now) begin
      halt_reg <= 1'b1;
    end
  end

  always_comb begin
    sel_c    = 1'b0;
    rd_c     = 1'b0;
    ld_ir_c  = 1'b0;
    halt_c   = 1'b0;
    inc_pc_c = 1'b0;
    ld_pc_c  = 1'b0;
    ld_ac_c  = 1'b0;
    wr_c     = 1'b0;
    data_e_c = 1'b0;
    if (rst) begin
      sel_c = 1'b1;
    end else if (halt_reg) begin
      halt_c = 1'b1;
    end else begin
      case (ph)
        PH_INST_ADDR: sel_c = 1'b1;
        PH_INST_FETCH: begin
          sel_c = 1'b1;
          rd_c  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel_c   = 1'b1;
          rd_c    = 1'b1;
          ld_ir_c = 1'b1;
        end
        PH_OP_ADDR: begin
          halt_c   = (op == OP_HLT);
          inc_pc_c = (op != OP_HLT);
        end
        PH_OP_FETCH: rd_c = aluop;
        PH_ALU_OP: begin
          rd_c     = aluop;
          inc_pc_c = (op == OP_SKZ) && bus.zero;
          ld_pc_c  = (op == OP_JMP);
          data_e_c = (op == OP_STO);
        end
        PH_STORE: begin
          rd_c     = aluop;
          ld_ac_c  = aluop;
          ld_pc_c  = (op == OP_JMP);
          wr_c     = (op == OP_STO);
          data_e_c = (op == OP_STO);
        end
        default: sel_c = 1'b0;
      endcase
    end
  end

  assign bus.phase  = phase_raw;
  assign bus.sel    = sel_c;
  assign bus.rd     = rd_c;
  assign bus.ld_ir  = ld_ir_c;
  assign bus.halt   = halt_c;
  assign bus.inc_pc = inc_pc_c;
  assign bus.ld_pc  = ld_pc_c;
  assign bus.ld_ac  = ld_ac_c;
  assign bus.wr     = wr_c;
  assign bus.data_e = data_e_c;

endmodule
